// File: rtl/vendor_pkg.sv
// vendor_multi shared types: coin encodings, coin values in nickels,
// and the controller state enum.
package vendor_pkg;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;
  localparam logic [1:0] COIN_ILLEGAL = 2'd3;

  localparam logic [2:0] NICKEL_VAL  = 3'd1;
  localparam logic [2:0] DIME_VAL    = 3'd2;
  localparam logic [2:0] QUARTER_VAL = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  function automatic logic [2:0] coin_value(
    input logic [1:0] ct
  );
    logic [2:0] v;
    v = 3'd0;
    unique case (ct)
      COIN_NICKEL:  v = NICKEL_VAL;
      COIN_DIME:    v = DIME_VAL;
      COIN_QUARTER: v = QUARTER_VAL;
      default:      v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vendor_multi_if.sv
// Vend and change valid/ready handshakes between the
// vendor_multi controller (master) and dispenser/hopper (slave).
interface vendor_multi_if #(
  parameter int PRODUCT_COUNT = 4
);
  localparam int IDX_W =
    (PRODUCT_COUNT > 1) ? $clog2(PRODUCT_COUNT) : 1;

  logic             vend_valid;
  logic             vend_ready;
  logic [IDX_W-1:0] vend_product;
  logic             change_valid;
  logic             change_ready;
  logic [1:0]       change_coin;

  modport master (
    output vend_valid,
    output vend_product,
    output change_valid,
    output change_coin,
    input  vend_ready,
    input  change_ready
  );

  modport slave (
    input  vend_valid,
    input  vend_product,
    input  change_valid,
    input  change_coin,
    output vend_ready,
    output change_ready
  );

endinterface

// File: rtl/nickels_to_bcd.sv
// Nickel count to BCD cents: multiply by five, then double-dabble.
// Purely combinational; digits beyond BCD_DIGITS are dropped.
module nickels_to_bcd #(
  parameter int CREDIT_WIDTH = 8,
  parameter int BCD_DIGITS   = 3
) (
  input  logic [CREDIT_WIDTH-1:0] nickels,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CW = CREDIT_WIDTH + 3;

  logic [CW-1:0] ext;
  logic [CW-1:0] cents;

  assign ext   = {3'b000, nickels};
  assign cents = (ext << 2) + ext;

  always_comb begin
    bcd = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[4*BCD_DIGITS-2:0], cents[i]};
    end
  end

endmodule

// File: rtl/vendor_multi.sv
// Multi-product vending controller with binary nickel credit.
// Define VENDOR_MULTI_REFUND_EN to add the cancel/refund input.
module vendor_multi
  import vendor_pkg::*;
#(
  parameter int PRODUCT_COUNT = 4,
  parameter int CREDIT_WIDTH  = 8,
  parameter int CREDIT_MAX    = 20,
  parameter logic [PRODUCT_COUNT*CREDIT_WIDTH-1:0] PRICES =
    {8'd6, 8'd5, 8'd4, 8'd3},
  parameter int BCD_DIGITS    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     coin_valid,
  input  logic [1:0]               coin_type,
  input  logic [PRODUCT_COUNT-1:0] select,
  input  logic                     vend_request,
`ifdef VENDOR_MULTI_REFUND_EN
  input  logic                     cancel,
`endif
  output logic                     coin_reject,
  output logic                     vend_denied,
  output logic [4*BCD_DIGITS-1:0]  credit_bcd,
  output logic [4*BCD_DIGITS-1:0]  cost_bcd,
  output logic                     busy,
  vendor_multi_if.master           vbus
);

  localparam int IDX_W =
    (PRODUCT_COUNT > 1) ? $clog2(PRODUCT_COUNT) : 1;
  localparam logic [CREDIT_WIDTH:0] MAX_EXT =
    (CREDIT_WIDTH + 1)'(CREDIT_MAX);

  function automatic bit prices_ok();
    for (int i = 0; i < PRODUCT_COUNT; i++) begin
      if (int'(PRICES[i*CREDIT_WIDTH +: CREDIT_WIDTH]) == 0 ||
          int'(PRICES[i*CREDIT_WIDTH +: CREDIT_WIDTH]) > CREDIT_MAX)
        return 1'b0;
    end
    return 1'b1;
  endfunction

  if (CREDIT_MAX * 5 >= 10 ** BCD_DIGITS) begin : g_bcd_err
    $error("CREDIT_MAX does not fit in BCD_DIGITS");
  end
  if (!prices_ok()) begin : g_price_err
    $error("PRICES entry is zero or above CREDIT_MAX");
  end

  state_t                  state, state_n;
  logic [CREDIT_WIDTH-1:0] credit, credit_n;
  logic [CREDIT_WIDTH-1:0] lat_price, price_n;
  logic [IDX_W-1:0]        lat_idx, idx_n;
  logic                    reject_q, reject_n;
  logic                    denied_q, denied_n;

  logic                    sel_ok;
  logic [CREDIT_WIDTH-1:0] sel_price;
  logic [IDX_W-1:0]        sel_idx;
  logic [CREDIT_WIDTH:0]   coin_sum;
  logic [1:0]              chg_coin;
  logic [CREDIT_WIDTH-1:0] chg_val;
  logic                    cancel_hit;
  logic                    coin_block;

`ifdef VENDOR_MULTI_REFUND_EN
  assign cancel_hit = cancel && (state == COLLECT);
  assign coin_block = cancel;
`else
  assign cancel_hit = 1'b0;
  assign coin_block = 1'b0;
`endif

  assign sel_ok = (select != '0) &&
    ((select & (select - PRODUCT_COUNT'(1))) == '0);

  always_comb begin
    sel_price = '0;
    sel_idx   = '0;
    for (int i = 0; i < PRODUCT_COUNT; i++) begin
      if (select[i]) begin
        sel_price = PRICES[i*CREDIT_WIDTH +: CREDIT_WIDTH];
        sel_idx   = IDX_W'(i);
      end
    end
    if (!sel_ok) begin
      sel_price = '0;
      sel_idx   = '0;
    end
  end

  assign coin_sum = {1'b0, credit} +
    (CREDIT_WIDTH + 1)'(coin_value(coin_type));

  // Greedy change: largest coin that does not exceed the credit owed
  always_comb begin
    chg_coin = COIN_NICKEL;
    chg_val  = CREDIT_WIDTH'(NICKEL_VAL);
    if (credit >= CREDIT_WIDTH'(QUARTER_VAL)) begin
      chg_coin = COIN_QUARTER;
      chg_val  = CREDIT_WIDTH'(QUARTER_VAL);
    end else if (credit >= CREDIT_WIDTH'(DIME_VAL)) begin
      chg_coin = COIN_DIME;
      chg_val  = CREDIT_WIDTH'(DIME_VAL);
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit;
    price_n  = lat_price;
    idx_n    = lat_idx;
    reject_n = 1'b0;
    denied_n = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (coin_valid) begin
          if (coin_type == COIN_ILLEGAL || coin_block ||
              coin_sum > MAX_EXT) begin
            reject_n = 1'b1;
          end else begin
            credit_n = coin_sum[CREDIT_WIDTH-1:0];
            state_n  = COLLECT;
          end
        end
        if (cancel_hit) begin
          state_n = CHANGE;
        end
        // A coin or cancel in the same cycle always beats a purchase
        if (vend_request) begin
          if (coin_valid || cancel_hit || !sel_ok ||
              credit < sel_price) begin
            denied_n = 1'b1;
          end else begin
            price_n = sel_price;
            idx_n   = sel_idx;
            state_n = VEND;
          end
        end
      end
      VEND: begin
        reject_n = coin_valid;
        if (vbus.vend_ready) begin
          credit_n = credit - lat_price;
          state_n  = (credit == lat_price) ? IDLE : CHANGE;
        end
      end
      CHANGE: begin
        reject_n = coin_valid;
        if (vbus.change_ready) begin
          credit_n = credit - chg_val;
          if (credit == chg_val) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      credit    <= '0;
      lat_price <= '0;
      lat_idx   <= '0;
      reject_q  <= 1'b0;
      denied_q  <= 1'b0;
    end else begin
      state     <= state_n;
      credit    <= credit_n;
      lat_price <= price_n;
      lat_idx   <= idx_n;
      reject_q  <= reject_n;
      denied_q  <= denied_n;
    end
  end

  assign coin_reject       = reject_q;
  assign vend_denied       = denied_q;
  assign busy              = (state == VEND) || (state == CHANGE);
  assign vbus.vend_valid   = (state == VEND);
  assign vbus.vend_product = lat_idx;
  assign vbus.change_valid = (state == CHANGE);
  assign vbus.change_coin  = chg_coin;

  nickels_to_bcd #(
    .CREDIT_WIDTH(CREDIT_WIDTH),
    .BCD_DIGITS  (BCD_DIGITS)
  ) u_credit_bcd (
    .nickels(credit),
    .bcd    (credit_bcd)
  );

  nickels_to_bcd #(
    .CREDIT_WIDTH(CREDIT_WIDTH),
    .BCD_DIGITS  (BCD_DIGITS)
  ) u_cost_bcd (
    .nickels(sel_price),
    .bcd    (cost_bcd)
  );

endmodule
